// File: rtl/iir_output_buffer_if.sv
// Handshake bundle between the IIR filter, the output buffer and its reader.
// The slave side is the buffer; the master side drives strobes and reads.
interface iir_output_buffer_if #(
  parameter int N     = 16,
  parameter int DEPTH = 8,
  parameter int SW    = $clog2(2*N)
);
  logic                   in_valid;
  logic [2*N-1:0]         in_y;
  logic [SW-1:0]          shift;
  logic                   rd_en;
  logic                   flag_clr;
  logic [N-1:0]           rd_data;
  logic                   rd_valid;
  logic                   empty;
  logic                   full;
  logic [$clog2(DEPTH):0] count;
  logic                   ovf;
  logic                   sat;

  modport master (
    output in_valid, in_y, shift, rd_en, flag_clr,
    input  rd_data, rd_valid, empty, full, count, ovf, sat
  );

  modport slave (
    input  in_valid, in_y, shift, rd_en, flag_clr,
    output rd_data, rd_valid, empty, full, count, ovf, sat
  );
endinterface

// File: rtl/iir_output_buffer.sv
// Rounds/shifts/saturates 2N-bit IIR results to N bits and queues them
// in a non-blocking FIFO with sticky drop and clip flags.
module iir_output_buffer #(
  parameter int N     = 16,
  parameter int DEPTH = 8,
  parameter int SW    = $clog2(2*N)
) (
  input logic clk,
  input logic rst,
  iir_output_buffer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);

  localparam logic signed [2*N:0] SMAX =
    {{(N+2){1'b0}}, {(N-1){1'b1}}};
  localparam logic signed [2*N:0] SMIN =
    {{(N+2){1'b1}}, {(N-1){1'b0}}};

  logic signed [2*N:0] ext;
  logic signed [2*N:0] inc;
  logic signed [2*N:0] rnd;
  logic signed [2*N:0] shr;
  logic [N-1:0]        conv;
  logic                clip;

  logic                s_valid;
  logic [N-1:0]        s_data;
  logic                s_sat;

  logic [N-1:0]        mem [DEPTH];
  logic [AW:0]         wptr;
  logic [AW:0]         rptr;
  logic [AW:0]         wptr_n;
  logic [AW:0]         rptr_n;
  logic [AW:0]         cnt;
  logic                empty_q;
  logic                full_q;
  logic [N-1:0]        rd_data_q;
  logic                rd_valid_q;
  logic                ovf_q;
  logic                sat_q;

  logic                rd_acc;
  logic                wr;
  logic                drop;

  // Round half toward +inf, then arithmetic shift, then clamp.
  always_comb begin
    ext = {bus.in_y[2*N-1], bus.in_y};
    inc = '0;
    if (bus.shift != '0)
      inc[bus.shift - 1'b1] = 1'b1;
    rnd  = ext + inc;
    shr  = rnd >>> bus.shift;
    conv = shr[N-1:0];
    clip = 1'b0;
    if (shr > SMAX) begin
      conv = {1'b0, {(N-1){1'b1}}};
      clip = 1'b1;
    end else if (shr < SMIN) begin
      conv = {1'b1, {(N-1){1'b0}}};
      clip = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_valid <= 1'b0;
      s_data  <= '0;
      s_sat   <= 1'b0;
    end else begin
      s_valid <= bus.in_valid;
      s_sat   <= bus.in_valid & clip;
      if (bus.in_valid)
        s_data <= conv;
    end
  end

  // A full FIFO still accepts a write when a read frees a slot this cycle.
  always_comb begin
    rd_acc = bus.rd_en & ~empty_q;
    wr     = s_valid & (~full_q | rd_acc);
    drop   = s_valid & full_q & ~rd_acc;
    wptr_n = wr     ? wptr + 1'b1 : wptr;
    rptr_n = rd_acc ? rptr + 1'b1 : rptr;
  end

  always_ff @(posedge clk) begin
    if (wr)
      mem[wptr[AW-1:0]] <= s_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr       <= '0;
      rptr       <= '0;
      cnt        <= '0;
      empty_q    <= 1'b1;
      full_q     <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      ovf_q      <= 1'b0;
      sat_q      <= 1'b0;
    end else begin
      wptr       <= wptr_n;
      rptr       <= rptr_n;
      empty_q    <= (wptr_n == rptr_n);
      full_q     <= (wptr_n[AW] != rptr_n[AW]) &&
                    (wptr_n[AW-1:0] == rptr_n[AW-1:0]);
      rd_valid_q <= rd_acc;
      if (rd_acc)
        rd_data_q <= mem[rptr[AW-1:0]];
      if (wr && !rd_acc)
        cnt <= cnt + 1'b1;
      else if (rd_acc && !wr)
        cnt <= cnt - 1'b1;
      ovf_q <= (ovf_q & ~bus.flag_clr) | drop;
      sat_q <= (sat_q & ~bus.flag_clr) | (s_valid & s_sat);
    end
  end

  assign bus.rd_data  = rd_data_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.empty    = empty_q;
  assign bus.full     = full_q;
  assign bus.count    = cnt;
  assign bus.ovf      = ovf_q;
  assign bus.sat      = sat_q;
endmodule

// File: tb/tb_iir_output_buffer.sv
// Random and directed bench for iir_output_buffer against a
// queue-based reference model.
module tb_iir_output_buffer;
  localparam int N     = 16;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;

  iir_output_buffer_if #(.N(N), .DEPTH(DEPTH)) bus ();

  iir_output_buffer #(.N(N), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int rv_cnt = 0;

  logic [15:0] mq[$];
  bit          p_v;
  bit          p_sat;
  logic [15:0] p_d;
  logic [15:0] m_rd;
  bit          m_rv;
  bit          m_ovf;
  bit          m_sat;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] conv(input logic [31:0] y,
                                       input int sh,
                                       output bit clip);
    longint v;
    v = longint'($signed(y));
    if (sh > 0)
      v = v + (longint'(1) << (sh - 1));
    v = v >>> sh;
    clip = 1'b0;
    if (v > 32767) begin
      v = 32767;
      clip = 1'b1;
    end else if (v < -32768) begin
      v = -32768;
      clip = 1'b1;
    end
    return v[15:0];
  endfunction

  task automatic check_outs();
    chk("rd_valid", 32'(bus.rd_valid), 32'(m_rv));
    chk("rd_data",  32'(bus.rd_data),  32'(m_rd));
    chk("count",    32'(bus.count),    32'(mq.size()));
    chk("empty",    32'(bus.empty),    32'(mq.size() == 0));
    chk("full",     32'(bus.full),     32'(mq.size() == DEPTH));
    chk("ovf",      32'(bus.ovf),      32'(m_ovf));
    chk("sat",      32'(bus.sat),      32'(m_sat));
  endtask

  task automatic step(input bit iv, input logic [31:0] y, input int sh,
                      input bit rd, input bit clr);
    bit acc;
    bit drop;
    bus.in_valid = iv;
    bus.in_y     = y;
    bus.shift    = 5'(sh);
    bus.rd_en    = rd;
    bus.flag_clr = clr;
    @(posedge clk);
    #1;
    acc  = rd && (mq.size() > 0);
    drop = 1'b0;
    if (acc) begin
      m_rd = mq.pop_front();
      m_rv = 1'b1;
    end else begin
      m_rv = 1'b0;
    end
    if (p_v) begin
      if (mq.size() < DEPTH) mq.push_back(p_d);
      else drop = 1'b1;
    end
    m_ovf = (m_ovf && !clr) || drop;
    m_sat = (m_sat && !clr) || (p_v && p_sat);
    p_v = iv;
    if (iv) p_d = conv(y, sh, p_sat);
    else    p_sat = 1'b0;
    if (m_rv) rv_cnt++;
    check_outs();
    bus.in_valid = 1'b0;
    bus.rd_en    = 1'b0;
    bus.flag_clr = 1'b0;
  endtask

  // Async assert mid-cycle, with a strobe held across the release edge.
  task automatic do_reset();
    rst = 1'b1;
    #1;
    mq.delete();
    p_v   = 1'b0;
    p_sat = 1'b0;
    m_rd  = '0;
    m_rv  = 1'b0;
    m_ovf = 1'b0;
    m_sat = 1'b0;
    check_outs();
    bus.in_valid = 1'b1;
    bus.in_y     = 32'h1234;
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.in_valid = 1'b0;
    check_outs();
  endtask

  task automatic rd_expect(input string tag, input logic [15:0] exp);
    step(1'b0, 32'h0, 0, 1'b1, 1'b0);
    chk(tag, 32'(bus.rd_data), 32'(exp));
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_y     = '0;
    bus.shift    = '0;
    bus.rd_en    = 1'b0;
    bus.flag_clr = 1'b0;
    #7;
    do_reset();

    step(1'b0, 32'h0, 0, 1'b1, 1'b0);
    chk("idle_rd_valid", 32'(bus.rd_valid), 32'h0);
    chk("idle_rd_data",  32'(bus.rd_data),  32'h0);

    step(1'b1, 32'h0001_2345, 8, 1'b0, 1'b0);
    step(1'b1, 32'h0000_0180, 8, 1'b0, 1'b0);
    step(1'b1, 32'hFFFF_FF80, 8, 1'b0, 1'b0);
    step(1'b1, 32'hFFFF_FE80, 8, 1'b0, 1'b0);
    step(1'b0, 32'h0, 0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 0, 1'b0, 1'b0);
    rd_expect("rnd0", 16'h0123);
    rd_expect("rnd1", 16'h0002);
    rd_expect("rnd2", 16'h0000);
    rd_expect("rnd3", 16'hFFFF);
    chk("rnd_nosat", 32'(bus.sat), 32'h0);

    step(1'b1, 32'h7FFF_FFFF, 0, 1'b0, 1'b0);
    step(1'b1, 32'h8000_0000, 0, 1'b0, 1'b0);
    step(1'b1, 32'h0000_8000, 0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 0, 1'b0, 1'b0);
    chk("sat_set", 32'(bus.sat), 32'h1);
    rd_expect("sat0", 16'h7FFF);
    rd_expect("sat1", 16'h8000);
    rd_expect("sat2", 16'h7FFF);
    step(1'b0, 32'h0, 0, 1'b0, 1'b1);
    chk("sat_clr", 32'(bus.sat), 32'h0);

    for (int i = 1; i <= 9; i++)
      step(1'b1, 32'(i), 0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 0, 1'b0, 1'b0);
    chk("ovf_count", 32'(bus.count), 32'd8);
    chk("ovf_full",  32'(bus.full),  32'h1);
    chk("ovf_set",   32'(bus.ovf),   32'h1);
    for (int i = 1; i <= 8; i++)
      rd_expect("ovf_rd", 16'(i));
    chk("ovf_empty", 32'(bus.empty), 32'h1);
    chk("ovf_cnt0",  32'(bus.count), 32'd0);
    step(1'b0, 32'h0, 0, 1'b0, 1'b1);

    for (int i = 0; i < 8; i++)
      step(1'b1, 32'(100 + i), 0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 0, 1'b0, 1'b0);
    step(1'b1, 32'h55, 0, 1'b0, 1'b0);
    rd_expect("frw_rd0", 16'd100);
    chk("frw_ovf",   32'(bus.ovf),   32'h0);
    chk("frw_count", 32'(bus.count), 32'd8);
    for (int i = 1; i < 8; i++)
      rd_expect("frw_rd", 16'(100 + i));
    rd_expect("frw_55", 16'h0055);

    step(1'b1, 32'h7, 0, 1'b0, 1'b0);
    chk("lat_t1", 32'(bus.empty), 32'h1);
    step(1'b0, 32'h0, 0, 1'b0, 1'b0);
    chk("lat_t2", 32'(bus.empty), 32'h0);
    rd_expect("lat_rd", 16'h0007);

    rv_cnt = 0;
    for (int i = 0; i < 20; i++)
      step(1'b1, $urandom, $urandom_range(0, 31), 1'b1, 1'b0);
    for (int i = 0; i < 3; i++)
      step(1'b0, 32'h0, 0, 1'b1, 1'b0);
    chk("burst_cnt", 32'(rv_cnt), 32'd20);
    chk("burst_ovf", 32'(bus.ovf), 32'h0);

    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 99) == 0)
        do_reset();
      else
        step($urandom_range(0, 1) == 1, $urandom,
             $urandom_range(0, 31), $urandom_range(0, 2) == 0,
             $urandom_range(0, 19) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
